scope_capture_ctrl: RTL and testbench

- Acquisition sequencer for the scope front end.
- Takes the signed 12-bit sample stream from the ADC driver, decimates it, and detects a level/edge trigger.
- Writes a circular capture buffer (external simple dual-port RAM) with a programmable pre-trigger depth.
- Reports completion plus the buffer start/trigger addresses to the host-side reader.

---
 rtl/scope_capture_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_scope_capture_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture_ctrl.sv
// Acquisition sequencer: decimates the ADC sample stream, detects a level/edge
// trigger and writes a circular capture buffer with programmable pre-trigger depth.
// Ports:
//   i_clk, i_rst_n              clock (also sample clock), async active-low reset
//   i_sample                    signed sample, new value every clock
//   i_arm, i_abort, i_force     control pulses (arm/latch config, abort, force trigger)
//   i_trig_level, i_trig_edge   trigger threshold and edge (0 rising, 1 falling)
//   i_pre_len, i_decim          pre-trigger depth, decimation ratio minus one
//   o_wr_en/o_wr_addr/o_wr_data capture RAM write port
//   o_busy, o_triggered, o_done status
//   o_trig_addr, o_start_addr   trigger sample address, oldest valid sample address
module scope_capture_ctrl #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DECIM_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_force,
  input  logic signed [DATA_W-1:0] i_trig_level,
  input  logic                     i_trig_edge,
  input  logic [ADDR_W-1:0]        i_pre_len,
  input  logic [DECIM_W-1:0]       i_decim,
  output logic                     o_wr_en,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [DATA_W-1:0]        o_wr_data,
  output logic                     o_busy,
  output logic                     o_triggered,
  output logic                     o_done,
  output logic [ADDR_W-1:0]        o_trig_addr,
  output logic [ADDR_W-1:0]        o_start_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [DECIM_W-1:0]        dcnt_q, dcnt_d;
  logic [DECIM_W-1:0]        decim_q, decim_d;
  logic signed [DATA_W-1:0]  level_q, level_d;
  logic                      edge_q, edge_d;
  logic [ADDR_W-1:0]         pre_len_q, pre_len_d;
  logic signed [DATA_W-1:0]  prev_q, prev_d;
  logic                      prev_vld_q, prev_vld_d;
  logic                      force_q, force_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]         wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic                      trig_q, trig_d;
  logic                      done_q, done_d;
  logic [ADDR_W-1:0]         trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]         start_addr_q, start_addr_d;

  logic              active;
  logic              tick;
  logic              level_hit;
  logic              trig_fire;
  logic [ADDR_W-1:0] post_len;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    decim_d      = decim_q;
    level_d      = level_q;
    edge_d       = edge_q;
    pre_len_d    = pre_len_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    force_d      = force_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_d       = trig_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    active    = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    tick      = active && (dcnt_q == '0);
    post_len  = ADDR_W'(DEPTH - 1) - pre_len_q;
    level_hit = edge_q ? ((prev_q >= level_q) && (i_sample <  level_q))
                       : ((prev_q <  level_q) && (i_sample >= level_q));
    // A pending or same-cycle force merges with a level hit into a single trigger
    trig_fire = (state_q == S_ARMED) && tick &&
                ((prev_vld_q && level_hit) || force_q || i_force);

    // Decimation counter runs only while capturing
    if (tick) begin
      dcnt_d = decim_q;
    end else if (active) begin
      dcnt_d = dcnt_q - DECIM_W'(1);
    end

    // Every tick in a capturing state writes the sample and becomes prev
    if (tick) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = ptr_q;
      wr_data_d  = i_sample;
      ptr_d      = ptr_q + ADDR_W'(1);
      prev_d     = i_sample;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_PRE: begin
        if (tick) begin
          if (cnt_q == pre_len_q - ADDR_W'(1)) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_ARMED: begin
        if (i_force && !tick) force_d = 1'b1;
        if (trig_fire) begin
          force_d      = 1'b0;
          trig_d       = 1'b1;
          trig_addr_d  = ptr_q;
          start_addr_d = ptr_q - pre_len_q;
          cnt_d        = '0;
          state_d      = (post_len == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (tick) begin
          if (cnt_q == post_len - ADDR_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        // IDLE / DONE: arm latches config and restarts the capture
        if (i_arm && !i_abort) begin
          level_d    = i_trig_level;
          edge_d     = i_trig_edge;
          pre_len_d  = i_pre_len;  // ADDR_W-wide field already bounded by DEPTH-1
          decim_d    = i_decim;
          ptr_d      = '0;
          cnt_d      = '0;
          dcnt_d     = '0;
          prev_vld_d = 1'b0;
          force_d    = 1'b0;
          trig_d     = 1'b0;
          state_d    = (i_pre_len == '0) ? S_ARMED : S_PRE;
        end
      end
    endcase

    // Abort wins over everything; addresses of the last capture are kept
    if (i_abort) begin
      state_d = S_IDLE;
      wr_en_d = 1'b0;
      trig_d  = 1'b0;
      force_d = 1'b0;
    end

    busy_d = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      dcnt_q       <= '0;
      decim_q      <= '0;
      level_q      <= '0;
      edge_q       <= 1'b0;
      pre_len_q    <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      decim_q      <= decim_d;
      level_q      <= level_d;
      edge_q       <= edge_d;
      pre_len_q    <= pre_len_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      force_q      <= force_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      trig_q       <= trig_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = busy_q;
  assign o_triggered  = trig_q;
  assign o_done       = done_q;
  assign o_trig_addr  = trig_addr_q;
  assign o_start_addr = start_addr_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl with a 16-entry buffer. Expected RAM writes are
// queued when a sample is driven and popped when the write strobe appears.
module tb_scope_capture_ctrl;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DECIM_W = 16;

  logic                     clk;
  logic                     rst_n;
  logic signed [DATA_W-1:0] i_sample;
  logic                     i_arm;
  logic                     i_abort;
  logic                     i_force;
  logic signed [DATA_W-1:0] i_trig_level;
  logic                     i_trig_edge;
  logic [ADDR_W-1:0]        i_pre_len;
  logic [DECIM_W-1:0]       i_decim;
  logic                     o_wr_en;
  logic [ADDR_W-1:0]        o_wr_addr;
  logic [DATA_W-1:0]        o_wr_data;
  logic                     o_busy;
  logic                     o_triggered;
  logic                     o_done;
  logic [ADDR_W-1:0]        o_trig_addr;
  logic [ADDR_W-1:0]        o_start_addr;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  wr_t               sbq[$];
  wr_t               e;
  wr_t               item;
  logic [DATA_W-1:0] ram [16];
  logic [ADDR_W-1:0] exp_ptr;
  int                cyc;
  int                checks;
  int                errors;

  scope_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM_W(DECIM_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample(i_sample), .i_arm(i_arm),
    .i_abort(i_abort), .i_force(i_force), .i_trig_level(i_trig_level),
    .i_trig_edge(i_trig_edge), .i_pre_len(i_pre_len), .i_decim(i_decim),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_triggered(o_triggered), .o_done(o_done),
    .o_trig_addr(o_trig_addr), .o_start_addr(o_start_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the queue head on the expected cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_wr_en) begin
          ram[o_wr_addr] = o_wr_data;
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", o_wr_addr,
                     $signed(o_wr_data), cyc);
          end else begin
            e = sbq.pop_front();
            if (o_wr_addr !== e.addr || o_wr_data !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL write got addr=%0d data=%0d cyc=%0d exp addr=%0d data=%0d cyc=%0d",
                       o_wr_addr, $signed(o_wr_data), cyc, e.addr, $signed(e.data), e.cyc);
            end
          end
        end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_write exp addr=%0d data=%0d at cyc=%0d got no strobe",
                   sbq[0].addr, $signed(sbq[0].data), sbq[0].cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // Drive one sample for one clock; w marks it as an expected RAM write
  task automatic drive(input int s, input bit w, input bit frc = 1'b0);
    i_sample = DATA_W'(s);
    i_force  = frc;
    if (w) begin
      item.addr = exp_ptr;
      item.data = DATA_W'(s);
      item.cyc  = cyc + 1;
      sbq.push_back(item);
      exp_ptr = exp_ptr + ADDR_W'(1);
    end
    @(negedge clk);
    i_force = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0);
  endtask

  // Arm, then scramble config inputs to show they are latched
  task automatic arm(input int lvl, input bit edg, input int pre, input int dec);
    i_trig_level = DATA_W'(lvl);
    i_trig_edge  = edg;
    i_pre_len    = ADDR_W'(pre);
    i_decim      = DECIM_W'(dec);
    i_arm        = 1'b1;
    i_sample     = '0;
    @(negedge clk);
    i_arm        = 1'b0;
    exp_ptr      = '0;
    i_trig_level = DATA_W'($urandom);
    i_trig_edge  = ~edg;
    i_pre_len    = ADDR_W'($urandom);
    i_decim      = DECIM_W'($urandom_range(1, 7));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #23;
    checks++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_done, o_trig_addr, o_start_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%0b addr=%0d data=%0d busy=%0b trg=%0b done=%0b ta=%0d sa=%0d exp all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_done, o_trig_addr, o_start_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_rising_ramp;
    arm(0, 1'b0, 4, 0);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %0b exp 1", o_busy); end
    for (int i = 0; i < 20; i++) drive(i - 8, 1'b1);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_triggered !== 1'b1) begin
      errors++;
      $display("FAIL t1_status got done=%0b busy=%0b trg=%0b exp 1 0 1", o_done, o_busy, o_triggered);
    end
    checks++;
    if (o_trig_addr !== 4'd8 || o_start_addr !== 4'd4) begin
      errors++;
      $display("FAIL t1_addrs got trig=%0d start=%0d exp 8 4", o_trig_addr, o_start_addr);
    end
    idle(3);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ram[(4 + k) % 16] !== DATA_W'(k - 4)) begin
        errors++;
        $display("FAIL t1_ram off=%0d got %0d exp %0d", k, $signed(ram[(4 + k) % 16]), k - 4);
      end
    end
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL t1_pending got %0d exp 0", sbq.size()); end
  endtask

  task automatic test_falling_wrap;
    arm(100, 1'b1, 4, 0);
    for (int i = 0; i < 54; i++) drive(200, 1'b1);
    drive(150, 1'b1);
    checks++;
    if (o_triggered !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL t2_hold got trg=%0b busy=%0b exp 0 1", o_triggered, o_busy);
    end
    drive(99, 1'b1);
    checks++;
    if (o_triggered !== 1'b1 || o_trig_addr !== 4'd7 || o_start_addr !== 4'd3) begin
      errors++;
      $display("FAIL t2_trig got trg=%0b trig=%0d start=%0d exp 1 7 3", o_triggered, o_trig_addr, o_start_addr);
    end
    for (int i = 0; i < 11; i++) drive(50 + i, 1'b1);
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL t2_done got %0b exp 1", o_done); end
    idle(2);
  endtask

  task automatic test_decim;
    int v;
    arm(0, 1'b0, 2, 3);
    for (int i = 0; i < 65; i++) begin
      v = (i == 9) ? 30 : (i >= 10) ? 20 : -50;
      drive(v, (i % 4) == 0);
    end
    checks++;
    if (o_done !== 1'b1 || o_trig_addr !== 4'd3 || o_start_addr !== 4'd1) begin
      errors++;
      $display("FAIL t3_result got done=%0b trig=%0d start=%0d exp 1 3 1", o_done, o_trig_addr, o_start_addr);
    end
    idle(2);
  endtask

  task automatic test_force_pre0;
    arm(0, 1'b0, 0, 0);
    drive(100, 1'b1, 1'b1);
    checks++;
    if (o_triggered !== 1'b1 || o_trig_addr !== 4'd0 || o_start_addr !== 4'd0) begin
      errors++;
      $display("FAIL t4_force got trg=%0b trig=%0d start=%0d exp 1 0 0", o_triggered, o_trig_addr, o_start_addr);
    end
    for (int i = 0; i < 14; i++) drive(101 + i, 1'b1);
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL t4_early_done got %0b exp 0", o_done); end
    drive(115, 1'b1);
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL t4_done got %0b exp 1", o_done); end
    idle(2);
  endtask

  task automatic test_pre15;
    arm(0, 1'b0, 15, 0);
    for (int i = 0; i < 15; i++) drive(-10, 1'b1);
    drive(-5, 1'b1);
    drive(5, 1'b1);
    checks++;
    if (o_done !== 1'b1 || o_trig_addr !== 4'd0 || o_start_addr !== 4'd1) begin
      errors++;
      $display("FAIL t5_result got done=%0b trig=%0d start=%0d exp 1 0 1", o_done, o_trig_addr, o_start_addr);
    end
    idle(2);
  endtask

  task automatic test_arm_abort_done;
    i_arm   = 1'b1;
    i_abort = 1'b1;
    drive(0, 1'b0);
    i_arm   = 1'b0;
    i_abort = 1'b0;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_triggered !== 1'b0) begin
      errors++;
      $display("FAIL t6_idle got done=%0b busy=%0b trg=%0b exp 0 0 0", o_done, o_busy, o_triggered);
    end
    idle(3);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL t6_stay_idle got busy=%0b exp 0", o_busy); end
  endtask

  task automatic test_abort_post;
    arm(0, 1'b0, 4, 0);
    for (int i = 0; i < 12; i++) drive(i - 8, 1'b1);
    i_abort = 1'b1;
    drive(4, 1'b0);
    i_abort = 1'b0;
    checks++;
    if (o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_triggered !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL t7_abort got en=%0b busy=%0b trg=%0b done=%0b exp 0 0 0 0", o_wr_en, o_busy, o_triggered, o_done);
    end
    checks++;
    if (o_trig_addr !== 4'd8 || o_start_addr !== 4'd4) begin
      errors++;
      $display("FAIL t7_hold_addrs got trig=%0d start=%0d exp 8 4", o_trig_addr, o_start_addr);
    end
    idle(3);
  endtask

  task automatic test_arm_in_pre;
    arm(0, 1'b0, 4, 0);
    drive(-10, 1'b1);
    drive(-10, 1'b1);
    i_arm     = 1'b1;
    i_pre_len = 4'd1;
    drive(-10, 1'b1);
    i_arm     = 1'b0;
    drive(10, 1'b1);
    drive(-10, 1'b1);
    checks++;
    if (o_triggered !== 1'b0) begin errors++; $display("FAIL t8_pre_trig got %0b exp 0", o_triggered); end
    drive(10, 1'b1);
    for (int i = 0; i < 11; i++) drive(i, 1'b1);
    checks++;
    if (o_done !== 1'b1 || o_trig_addr !== 4'd5 || o_start_addr !== 4'd1) begin
      errors++;
      $display("FAIL t8_result got done=%0b trig=%0d start=%0d exp 1 5 1", o_done, o_trig_addr, o_start_addr);
    end
    idle(2);
  endtask

  task automatic test_async_reset;
    arm(0, 1'b0, 2, 0);
    for (int i = 0; i < 5; i++) drive(-10, 1'b1);
    i_sample = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_done, o_trig_addr, o_start_addr} !== '0) begin
      errors++;
      $display("FAIL t9_async_reset got en=%0b addr=%0d data=%0d busy=%0b trg=%0b done=%0b ta=%0d sa=%0d exp all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_busy, o_triggered, o_done, o_trig_addr, o_start_addr);
    end
    @(negedge clk);
    sbq.delete();
    rst_n = 1'b1;
    idle(3);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL t9_after_reset got busy=%0b exp 0", o_busy); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_ptr      = '0;
    i_sample     = '0;
    i_arm        = 1'b0;
    i_abort      = 1'b0;
    i_force      = 1'b0;
    i_trig_level = '0;
    i_trig_edge  = 1'b0;
    i_pre_len    = '0;
    i_decim      = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    test_reset();
    test_rising_ramp();
    test_falling_wrap();
    test_decim();
    test_force_pre0();
    test_pre15();
    test_arm_abort_done();
    test_abort_post();
    test_arm_in_pre();
    test_async_reset();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL final_pending got %0d exp 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
